pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/pipeline_controller_hazard_detect.sv | 64 ++++++
 rtl/pipeline_controller.sv | 120 ++++++++++++
 tb/tb_pipeline_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for pipeline_controller and hazard_detect: FSM states, stage tags,
// forwarding selects and PC write-enable bit positions.
package pipeline_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_HAZARD   = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_MEM_WAIT = 2'b11
  } ctrl_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             reg_write;
    logic             is_load;
    logic             mem_access;
    logic             overwrite_nz;
  } stage_tag_t;

  localparam int TAG_W = $bits(stage_tag_t);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX_MEM  = 2'b01;
  localparam logic [1:0] FWD_MEM_WB  = 2'b10;

  localparam int PC_JMP_COND_LO = 0;
  localparam int PC_JMP_UNCOND  = 1;
  localparam int PC_JMP_COND_HI = 2;

  function automatic logic is_cond_jump(input logic [2:0] pc_write_en);
    return pc_write_en[PC_JMP_COND_HI] | pc_write_en[PC_JMP_COND_LO];
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// hazard_detect: combinational compare of the decode sources against the EX/MEM tags.
// PIPELINE_FORWARDING_EN selects forwarding (load-use stall only) over stall-on-every-RAW.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic             dec_valid,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic             use_a,
  input  logic             use_b,
  input  logic             cond_jump,
  input  logic [TAG_W-1:0] ex_tag,
  input  logic [TAG_W-1:0] mem_tag,
  output logic             raw_stall,
  output logic             flag_hazard,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

  stage_tag_t ex_t;
  stage_tag_t mem_t;
  logic [NREG-1:0] ex_pend;
  logic [NREG-1:0] mem_pend;
  logic a_ex, a_mem, b_ex, b_mem;
  logic unused_tag_bits;

  assign ex_t  = ex_tag;
  assign mem_t = mem_tag;

  // One-hot view of which registers have a write in flight in each stage.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    assign ex_pend[gi]  = ex_t.valid  && ex_t.reg_write  && (ex_t.dst  == REG_W'(gi));
    assign mem_pend[gi] = mem_t.valid && mem_t.reg_write && (mem_t.dst == REG_W'(gi));
  end

  assign a_ex  = dec_valid && use_a && ex_pend[src_a];
  assign a_mem = dec_valid && use_a && mem_pend[src_a];
  assign b_ex  = dec_valid && use_b && ex_pend[src_b];
  assign b_mem = dec_valid && use_b && mem_pend[src_b];

  assign flag_hazard = dec_valid && cond_jump && ex_t.valid && ex_t.overwrite_nz;

  always_comb begin
    raw_stall = 1'b0;
    fwd_a_sel = FWD_REGFILE;
    fwd_b_sel = FWD_REGFILE;
`ifdef PIPELINE_FORWARDING_EN
    // The younger producer (EX) wins; a load still in EX has no data to forward yet.
    raw_stall = (a_ex || b_ex) && ex_t.is_load;
    if (a_ex)       fwd_a_sel = ex_t.is_load ? FWD_REGFILE : FWD_EX_MEM;
    else if (a_mem) fwd_a_sel = FWD_MEM_WB;
    if (b_ex)       fwd_b_sel = ex_t.is_load ? FWD_REGFILE : FWD_EX_MEM;
    else if (b_mem) fwd_b_sel = FWD_MEM_WB;
`else
    raw_stall = a_ex || a_mem || b_ex || b_mem;
`endif
  end

  assign unused_tag_bits = ^{ex_t.mem_access, ex_t.is_load, mem_t.is_load,
                             mem_t.mem_access, mem_t.overwrite_nz};

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush/bubble/forward control for a 5-stage pipeline.
// Optional forwarding via macro PIPELINE_FORWARDING_EN (handled in hazard_detect).
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_src_a,
  input  logic [REG_W-1:0] dec_src_b,
  input  logic             dec_use_a,
  input  logic             dec_use_b,
  input  logic [REG_W-1:0] dec_dst,
  input  logic             dec_reg_write,
  input  logic             dec_is_load,
  input  logic [2:0]       dec_pc_write_en,
  input  logic             dec_overwrite_nz,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       ctrl_state
);

  ctrl_state_e state;
  stage_tag_t  ex_tag;
  stage_tag_t  mem_tag;
  stage_tag_t  dec_tag;
  logic        pend_branch;

  logic       raw_stall, flag_hazard;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_stall, take_branch, hazard;
  logic       stall, flush, bubble;

  hazard_detect #(.NREG(NREG)) u_hazard (
    .dec_valid   (dec_valid),
    .src_a       (dec_src_a),
    .src_b       (dec_src_b),
    .use_a       (dec_use_a),
    .use_b       (dec_use_b),
    .cond_jump   (is_cond_jump(dec_pc_write_en)),
    .ex_tag      (ex_tag),
    .mem_tag     (mem_tag),
    .raw_stall   (raw_stall),
    .flag_hazard (flag_hazard),
    .fwd_a_sel   (fwd_a),
    .fwd_b_sel   (fwd_b)
  );

  // dec_is_load without a register write marks a store: a memory access with no result.
  always_comb begin
    dec_tag              = '0;
    dec_tag.valid        = dec_valid;
    dec_tag.dst          = dec_dst;
    dec_tag.reg_write    = dec_reg_write;
    dec_tag.is_load      = dec_is_load && dec_reg_write;
    dec_tag.mem_access   = dec_is_load;
    dec_tag.overwrite_nz = dec_overwrite_nz;
  end

  always_comb begin
    mem_stall   = mem_tag.valid && mem_tag.mem_access && !mem_ready;
    take_branch = ex_branch_taken || pend_branch;
    // The decode slot behind a taken branch was flushed, so it cannot raise a hazard.
    hazard      = (raw_stall || flag_hazard) && (state != ST_FLUSH);
    stall       = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    if (mem_stall) begin
      stall = 1'b1;
    end else if (take_branch) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (state == ST_FLUSH) begin
      bubble = 1'b1;
    end else if (hazard) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else begin
      flush = dec_valid && dec_pc_write_en[PC_JMP_UNCOND];
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign pc_stall   = rst && stall;
  assign fd_stall   = rst && stall;
  assign fd_flush   = rst && flush;
  assign de_bubble  = rst && bubble;
  assign fwd_a_sel  = rst ? fwd_a : FWD_REGFILE;
  assign fwd_b_sel  = rst ? fwd_b : FWD_REGFILE;
  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      ex_tag      <= '0;
      mem_tag     <= '0;
      pend_branch <= 1'b0;
    end else if (mem_stall) begin
      // Whole pipe freezes; a branch resolving meanwhile is replayed on release.
      state       <= ST_MEM_WAIT;
      pend_branch <= pend_branch || ex_branch_taken;
    end else begin
      pend_branch <= 1'b0;
      mem_tag     <= ex_tag;
      ex_tag      <= bubble ? '0 : dec_tag;
      if (take_branch)  state <= ST_FLUSH;
      else if (hazard)  state <= ST_HAZARD;
      else              state <= ST_RUN;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed and randomized bench for pipeline_controller against an in-flight instruction list model.
module tb_pipeline_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dec_valid, dec_use_a, dec_use_b, dec_reg_write, dec_is_load;
  logic       dec_overwrite_nz, ex_branch_taken, mem_ready;
  logic [3:0] dec_src_a, dec_src_b, dec_dst;
  logic [2:0] dec_pc_write_en;
  logic       pc_stall, fd_stall, fd_flush, de_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel, ctrl_state;

  always #5 clk = ~clk;

  pipeline_controller #(.NREG(16)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dst(dec_dst),
    .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .dec_pc_write_en(dec_pc_write_en), .dec_overwrite_nz(dec_overwrite_nz),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_bubble(de_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ctrl_state(ctrl_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // Instructions in flight after decode: pipe[0] is in EX, pipe[1] is in MEM.
  typedef struct packed {bit v; bit [3:0] dst; bit wr; bit ld; bit mem; bit nz;} rec_t;
  rec_t     pipe[$];
  bit [1:0] m_state;
  bit       m_pend;
  bit       e_stall, e_flush, e_bubble, e_hold;
  bit [1:0] e_fa, e_fb, e_next;
  logic       o_stall, o_flush, o_bubble;
  logic [1:0] o_fa, o_fb, o_st;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe = '{rec_t'('0), rec_t'('0)};
    m_state = 2'b00;
    m_pend = 1'b0;
  endtask

  // Nearest in-flight writer of src decides stall/forward source.
  function automatic bit [1:0] src_sel(input bit [3:0] src, input bit used, output bit stall);
    stall = 1'b0;
    if (!(dec_valid && used)) return 2'b00;
    for (int age = 0; age < 2; age++) begin
      if (pipe[age].v && pipe[age].wr && pipe[age].dst == src) begin
`ifdef PIPELINE_FORWARDING_EN
        if (age == 0 && pipe[age].ld) begin
          stall = 1'b1;
          return 2'b00;
        end
        return (age == 0) ? 2'b01 : 2'b10;
`else
        stall = 1'b1;
        return 2'b00;
`endif
      end
    end
    return 2'b00;
  endfunction

  task automatic predict();
    bit sa, sb, flag, hz, br;
    e_hold = pipe[1].v && pipe[1].mem && !mem_ready;
    br     = ex_branch_taken || m_pend;
    e_fa   = src_sel(dec_src_a, dec_use_a, sa);
    e_fb   = src_sel(dec_src_b, dec_use_b, sb);
    flag   = dec_valid && (dec_pc_write_en[2] || dec_pc_write_en[0]) && pipe[0].v && pipe[0].nz;
    hz     = (sa || sb || flag) && (m_state != 2'b10);
    e_stall = 0; e_flush = 0; e_bubble = 0;
    if (e_hold)                 begin e_stall = 1; e_next = 2'b11; end
    else if (br)                begin e_flush = 1; e_bubble = 1; e_next = 2'b10; end
    else if (m_state == 2'b10)  begin e_bubble = 1; e_next = 2'b00; end
    else if (hz)                begin e_stall = 1; e_bubble = 1; e_next = 2'b01; end
    else begin
      e_flush = dec_valid && dec_pc_write_en[1];
      e_next = 2'b00;
    end
  endtask

  task automatic model_edge();
    rec_t r;
    if (e_hold) begin
      m_state = 2'b11;
      m_pend = m_pend || ex_branch_taken;
    end else begin
      r = '0;
      if (dec_valid && !e_bubble) begin
        r.v = 1; r.dst = dec_dst; r.wr = dec_reg_write;
        r.ld = dec_is_load && dec_reg_write; r.mem = dec_is_load; r.nz = dec_overwrite_nz;
      end
      void'(pipe.pop_back());
      pipe.push_front(r);
      m_pend = 1'b0;
      m_state = e_next;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    predict();
    o_stall = pc_stall; o_flush = fd_flush; o_bubble = de_bubble;
    o_fa = fwd_a_sel; o_fb = fwd_b_sel; o_st = ctrl_state;
    chk1("pc_stall", pc_stall, e_stall);
    chk1("fd_stall", fd_stall, e_stall);
    chk1("fd_flush", fd_flush, e_flush);
    chk1("de_bubble", de_bubble, e_bubble);
    chk2("fwd_a_sel", fwd_a_sel, e_fa);
    chk2("fwd_b_sel", fwd_b_sel, e_fb);
    chk2("ctrl_state", ctrl_state, m_state);
    @(posedge clk);
    model_edge();
    cyc_n++;
    #1;
  endtask

  task automatic drive(input bit v, input bit [3:0] sa, input bit ua, input bit [3:0] sb,
                       input bit ub, input bit [3:0] d, input bit wr, input bit ld,
                       input bit [2:0] pcwe, input bit nz);
    dec_valid = v; dec_src_a = sa; dec_use_a = ua; dec_src_b = sb; dec_use_b = ub;
    dec_dst = d; dec_reg_write = wr; dec_is_load = ld; dec_pc_write_en = pcwe;
    dec_overwrite_nz = nz;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_pc_stall"}, pc_stall, 1'b0);
    chk1({tag, "_fd_flush"}, fd_flush, 1'b0);
    chk1({tag, "_de_bubble"}, de_bubble, 1'b0);
    chk2({tag, "_fwd_a"}, fwd_a_sel, 2'b00);
    chk2({tag, "_state"}, ctrl_state, 2'b00);
  endtask

  initial begin
    idle();
    // Reset with inputs that would otherwise flush.
    ex_branch_taken = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0);
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // RAW on R3 from an ALU producer.
    drive(1, 0, 0, 0, 0, 4'd3, 1, 0, 3'b000, 0); cyc();
    drive(1, 4'd3, 1, 4'd9, 0, 4'd7, 1, 0, 3'b000, 0); cyc();
`ifdef PIPELINE_FORWARDING_EN
    chk1("raw_b_stall", o_stall, 1'b0); chk2("raw_b_fwd", o_fa, 2'b01);
    cyc(); chk2("raw_c_fwd", o_fa, 2'b10); chk1("raw_c_stall", o_stall, 1'b0);
    cyc(); chk2("raw_d_state", o_st, 2'b00);
`else
    chk1("raw_b_stall", o_stall, 1'b1); chk1("raw_b_bubble", o_bubble, 1'b1);
    cyc(); chk1("raw_c_stall", o_stall, 1'b1); chk2("raw_c_state", o_st, 2'b01);
    cyc(); chk1("raw_d_stall", o_stall, 1'b0); chk2("raw_d_state", o_st, 2'b01);
`endif
    idle(); cyc(); chk2("raw_e_state", o_st, 2'b00);
    cyc(); cyc();

    // ALU R5 then load R5 consumers.
    drive(1, 0, 0, 0, 0, 4'd5, 1, 0, 3'b000, 0); cyc();
    drive(1, 4'd5, 1, 0, 0, 4'd8, 1, 0, 3'b000, 0); cyc();
`ifdef PIPELINE_FORWARDING_EN
    chk1("alu_use_stall", o_stall, 1'b0); chk2("alu_use_fwd", o_fa, 2'b01);
`else
    chk1("alu_use_stall", o_stall, 1'b1); chk2("alu_use_fwd", o_fa, 2'b00);
`endif
    idle(); cyc(); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 4'd5, 1, 1, 3'b000, 0); cyc();
    drive(1, 0, 0, 4'd5, 1, 4'd8, 1, 0, 3'b000, 0); cyc();
    chk1("load_use_stall", o_stall, 1'b1);
    cyc();
`ifdef PIPELINE_FORWARDING_EN
    chk1("load_use_release", o_stall, 1'b0); chk2("load_use_fwd", o_fb, 2'b10);
`else
    chk1("load_use_release", o_stall, 1'b1); chk2("load_use_fwd", o_fb, 2'b00);
`endif
    idle(); cyc(); cyc(); cyc();

    // Taken branch while in HAZARD.
    drive(1, 0, 0, 0, 0, 4'd3, 1, 1, 3'b000, 0); cyc();
    drive(1, 4'd3, 1, 0, 0, 4'd4, 1, 0, 3'b000, 0); cyc();
    ex_branch_taken = 1'b1; cyc();
    chk2("hz_br_state", o_st, 2'b01); chk1("hz_br_flush", o_flush, 1'b1);
    chk1("hz_br_bubble", o_bubble, 1'b1); chk1("hz_br_stall", o_stall, 1'b0);
    idle(); cyc();
    chk2("flush_state", o_st, 2'b10); chk1("flush_bubble", o_bubble, 1'b1);
    chk1("flush_noflush", o_flush, 1'b0);
    cyc(); chk2("flush_exit", o_st, 2'b00);
    cyc(); cyc();

    // Store held in MEM, branch resolved during the wait.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0); cyc();
    idle(); cyc();
    mem_ready = 1'b0; cyc(); chk1("mw1_stall", o_stall, 1'b1);
    ex_branch_taken = 1'b1; cyc();
    chk1("mw2_stall", o_stall, 1'b1); chk1("mw2_flush", o_flush, 1'b0); chk2("mw2_state", o_st, 2'b11);
    ex_branch_taken = 1'b0; cyc(); chk1("mw3_stall", o_stall, 1'b1);
    mem_ready = 1'b1; cyc();
    chk1("mw4_stall", o_stall, 1'b0); chk1("mw4_flush", o_flush, 1'b1); chk2("mw4_state", o_st, 2'b11);
    cyc(); chk2("mw5_state", o_st, 2'b10);
    cyc(); cyc();

    // Flag hazard vs unconditional jump.
    drive(1, 0, 0, 0, 0, 4'd1, 1, 0, 3'b000, 1); cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0); cyc();
    chk1("flag_stall", o_stall, 1'b1); chk1("flag_flush", o_flush, 1'b0);
    cyc(); chk1("flag_release", o_stall, 1'b0);
    drive(1, 0, 0, 0, 0, 4'd1, 1, 0, 3'b000, 1); cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0); cyc();
    chk1("jmp_flush", o_flush, 1'b1); chk1("jmp_stall", o_stall, 1'b0); chk1("jmp_bubble", o_bubble, 1'b0);
    idle(); cyc(); cyc();

    // Asynchronous reset in MEM_WAIT.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0); cyc();
    idle(); cyc();
    mem_ready = 1'b0; cyc();
    ex_branch_taken = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0);
    #2; rst = 1'b0; #1;
    check_all_zero("async_rst");
    @(negedge clk);
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    mem_ready = 1'b0; cyc();
    chk1("post_rst_stall", o_stall, 1'b0); chk2("post_rst_state", o_st, 2'b00);
    idle(); cyc();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      dec_valid        = ($urandom_range(0, 3) != 0);
      dec_src_a        = 4'($urandom_range(0, 3));
      dec_src_b        = 4'($urandom_range(0, 3));
      dec_use_a        = ($urandom_range(0, 1) != 0);
      dec_use_b        = ($urandom_range(0, 1) != 0);
      dec_dst          = 4'($urandom_range(0, 3));
      dec_reg_write    = ($urandom_range(0, 3) != 0);
      dec_is_load      = ($urandom_range(0, 3) == 0);
      dec_overwrite_nz = ($urandom_range(0, 2) == 0);
      dec_pc_write_en  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      ex_branch_taken  = ($urandom_range(0, 9) == 0);
      mem_ready        = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
